auth_initiator_ctrl: RTL and testbench
======================================

Name: auth_initiator_ctrl

Overview:
Parametrised USB Type-C Authentication initiator controller. It builds a request message (GET_DIGESTS, GET_CERTIFICATE or CHALLENGE), issues it with a one-cycle request strobe, and waits for the responder's message under a cycle-count timeout. A timed-out request is retransmitted up to a retry limit. The response header is checked and a completion status is reported to the host-side policy logic.

Parameters:
MSG_W, 1000, message width in bits; must be >= 16.
PROTO_VER, 8'h01, protocol version byte placed in and expected from messages.
TIMEOUT_CYC, 1000, WAIT-state cycles per attempt before a timeout is declared; must be >= 1.
MAX_RETRIES, 3, retransmissions allowed after the first attempt.
Local: CW = $clog2(TIMEOUT_CYC+1); RW = $clog2(MAX_RETRIES+1).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
start_in  in  1  starts a transaction; sampled only in IDLE.
req_type_in  in  2  request type: 00 GET_DIGESTS (0x81), 01 GET_CERTIFICATE (0x82), 10 CHALLENGE (0x83), 11 reserved.
req_payload_in  in  MSG_W-16  request payload; latched with start_in.
read_req_in  in  1  response-valid strobe from the responder.
auth_msg_init_in  in  MSG_W  response message; valid when read_req_in=1.
read_req_out  out  1  request-valid strobe; one cycle per transmission.
auth_msg_init_out  out  MSG_W  request message; held stable from SEND until the next transaction.
busy_out  out  1  high in every state other than IDLE.
done_out  out  1  one-cycle completion pulse.
status_out  out  2  result: 00 OK, 01 ERR_RESP, 10 TIMEOUT, 11 PROTOCOL. Held until the next start.
retry_cnt_out  out  RW  retransmissions used in the current or last transaction.
resp_msg_out  out  MSG_W  last captured response; held until the next capture.

Behaviour:
- Message format: [MSG_W-1:MSG_W-8] is the version byte, [MSG_W-9:MSG_W-16] is the message type, and the remaining low bits are payload.
- Expected response type = request code & 8'h7F (DIGESTS 0x01, CERTIFICATE 0x02, CHALLENGE_AUTH 0x03). ERROR type = 8'h7F.
- Reset: state IDLE; all outputs 0 (including both MSG_W buses); timeout counter and retry counter 0.
- Reset mid-transaction aborts immediately, with no done_out pulse.
- States: IDLE, SEND, WAIT, CHECK, DONE.
- IDLE, start_in=1, req_type_in != 11:
  - latch type and payload;
  - load auth_msg_init_out = {PROTO_VER, code, payload};
  - clear retry_cnt_out and status_out;
  - go to SEND.
- IDLE, start_in=1, req_type_in = 11: go to DONE with status 11. No request is sent.
- start_in while busy_out=1 is ignored.
- SEND (one cycle): read_req_out=1; timeout counter cleared; next state WAIT.
- WAIT: the counter starts at 0 and increments once per cycle.
  - read_req_in=1: capture auth_msg_init_in into resp_msg_out; go to CHECK.
  - Otherwise, if counter == TIMEOUT_CYC-1:
    - if retry_cnt_out < MAX_RETRIES: increment retry_cnt_out and go to SEND;
    - else go to DONE with status 10.
  - A response arriving in the timeout cycle wins over the timeout.
- CHECK (one cycle), in priority order:
  - version != PROTO_VER → 11;
  - type == 7F → 01;
  - type == expected → 00;
  - else 11.
  - Next state DONE.
- DONE: done_out=1 for one cycle; next state IDLE.
- read_req_in outside WAIT is ignored, and resp_msg_out does not change.
- Latency:
  - start sampled at cycle 0 → read_req_out in cycle 1;
  - response strobe in cycle k → done_out in cycle k+2.
- Each attempt allows exactly TIMEOUT_CYC WAIT cycles; the retransmit strobe occurs in the next cycle.

Test Plan:
- TIMEOUT_CYC=8, MAX_RETRIES=2. start_in at cycle 0, type 00, responder replies at cycle 4 with {01,01,...} → read_req_out at cycle 1; auth_msg_init_out[MSG_W-9:MSG_W-16]=0x81; done_out at cycle 6; status 00; retry_cnt_out 0; resp_msg_out equals the reply.
- Same parameters, responder silent → read_req_out in cycles 1, 10, 19; done_out at cycle 28; status 10; retry_cnt_out 2.
- First attempt silent, reply at cycle 12 → one retransmit at cycle 10; done_out at cycle 14; status 00; retry_cnt_out 1. A reply landing exactly in the timeout cycle (cycle 9) gives done at cycle 11 with no retransmit.
- Type 10 answered with type 0x7F → status 01. Type 10 answered with type 0x02 → status 11. Reply with version 0x02 → status 11 even if the type matches.
- req_type_in=11 → no read_req_out; done_out at cycle 1; status 11. A second start_in pulse during WAIT is ignored: auth_msg_init_out is unchanged and there is no extra strobe.
- reset asserted during WAIT → next cycle busy_out=0, all outputs 0, no done_out. read_req_in pulsed in IDLE leaves resp_msg_out unchanged.

Source files
------------

// File: rtl/auth_initiator_ctrl.sv
// USB Type-C Authentication initiator controller.
// Builds a request message, issues it with a one-cycle strobe, waits for the
// responder under a per-attempt cycle timeout with bounded retransmission,
// checks the response header and reports a completion status.
module auth_initiator_ctrl #(
  parameter int          MSG_W       = 1000,
  parameter logic [7:0]  PROTO_VER   = 8'h01,
  parameter int          TIMEOUT_CYC = 1000,
  parameter int          MAX_RETRIES = 3,
  localparam int         CW          = $clog2(TIMEOUT_CYC + 1),
  localparam int         RW          = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_in,
  input  logic [1:0]         req_type_in,
  input  logic [MSG_W-17:0]  req_payload_in,
  input  logic               read_req_in,
  input  logic [MSG_W-1:0]   auth_msg_init_in,
  output logic               read_req_out,
  output logic [MSG_W-1:0]   auth_msg_init_out,
  output logic               busy_out,
  output logic               done_out,
  output logic [1:0]         status_out,
  output logic [RW-1:0]      retry_cnt_out,
  output logic [MSG_W-1:0]   resp_msg_out
);

  localparam logic [1:0] STAT_OK       = 2'b00;
  localparam logic [1:0] STAT_ERR_RESP = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT  = 2'b10;
  localparam logic [1:0] STAT_PROTOCOL = 2'b11;
  localparam logic [7:0] TYPE_ERROR    = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Request code for a valid request type; reserved type maps to zero.
  function automatic logic [7:0] req_code(input logic [1:0] req_type);
    logic [7:0] code;
    case (req_type)
      2'b00:   code = 8'h81;
      2'b01:   code = 8'h82;
      2'b10:   code = 8'h83;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  // Header check of a captured response against the outstanding request.
  function automatic logic [1:0] resp_status(input logic [7:0] ver,
                                             input logic [7:0] typ,
                                             input logic [7:0] exp_typ);
    logic [1:0] st;
    if (ver != PROTO_VER) begin
      st = STAT_PROTOCOL;
    end else if (typ == TYPE_ERROR) begin
      st = STAT_ERR_RESP;
    end else if (typ == exp_typ) begin
      st = STAT_OK;
    end else begin
      st = STAT_PROTOCOL;
    end
    return st;
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [1:0]         status_q, status_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [MSG_W-1:0]   resp_q, resp_d;
  logic               req_strobe_q, req_strobe_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    status_d = status_q;
    msg_d    = msg_q;
    resp_d   = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          retry_d = '0;
          if (req_type_in != 2'b11) begin
            msg_d    = {PROTO_VER, req_code(req_type_in), req_payload_in};
            status_d = STAT_OK;
            state_d  = ST_SEND;
          end else begin
            // Reserved type: finish immediately without transmitting.
            status_d = STAT_PROTOCOL;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response in the final counted cycle beats the timeout.
        if (read_req_in) begin
          resp_d  = auth_msg_init_in;
          state_d = ST_CHECK;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + RW'(1);
            state_d = ST_SEND;
          end else begin
            status_d = STAT_TIMEOUT;
            state_d  = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        status_d = resp_status(resp_q[MSG_W-1 -: 8], resp_q[MSG_W-9 -: 8],
                               msg_q[MSG_W-9 -: 8] & 8'h7F);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes and busy are registered from the next state so they line up
    // with the state they describe.
    req_strobe_d = (state_d == ST_SEND);
    done_d       = (state_d == ST_DONE);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      status_q     <= 2'b00;
      msg_q        <= '0;
      resp_q       <= '0;
      req_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      status_q     <= status_d;
      msg_q        <= msg_d;
      resp_q       <= resp_d;
      req_strobe_q <= req_strobe_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign read_req_out      = req_strobe_q;
  assign auth_msg_init_out = msg_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
  assign status_out        = status_q;
  assign retry_cnt_out     = retry_q;
  assign resp_msg_out      = resp_q;

endmodule

// File: tb/tb_auth_initiator_ctrl.sv
// Self-checking bench for auth_initiator_ctrl: a transaction-level timeline
// model predicts every output on every cycle from start cycle, reply cycle
// and reply contents; directed transactions add literal pins.
module tb_auth_initiator_ctrl;

  localparam int         MSG_W = 32;
  localparam int         T     = 8;
  localparam int         M     = 2;
  localparam int         RW    = 2;
  localparam logic [7:0] PV    = 8'h01;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_in;
  logic [1:0]        req_type_in;
  logic [MSG_W-17:0] req_payload_in;
  logic              read_req_in;
  logic [MSG_W-1:0]  auth_msg_init_in;
  logic              read_req_out;
  logic [MSG_W-1:0]  auth_msg_init_out;
  logic              busy_out;
  logic              done_out;
  logic [1:0]        status_out;
  logic [RW-1:0]     retry_cnt_out;
  logic [MSG_W-1:0]  resp_msg_out;

  always #5 clk = ~clk;

  auth_initiator_ctrl #(
    .MSG_W(MSG_W), .PROTO_VER(PV), .TIMEOUT_CYC(T), .MAX_RETRIES(M)
  ) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .req_type_in(req_type_in),
    .req_payload_in(req_payload_in), .read_req_in(read_req_in),
    .auth_msg_init_in(auth_msg_init_in), .read_req_out(read_req_out),
    .auth_msg_init_out(auth_msg_init_out), .busy_out(busy_out),
    .done_out(done_out), .status_out(status_out),
    .retry_cnt_out(retry_cnt_out), .resp_msg_out(resp_msg_out)
  );

  typedef struct packed {
    logic             rr;
    logic             dn;
    logic             bz;
    logic [1:0]       st;
    logic [RW-1:0]    rt;
    logic [MSG_W-1:0] msg;
    logic [MSG_W-1:0] resp;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Current transaction as seen by the model (absolute cycle numbers).
  bit               have_txn = 1'b0;
  int               t_s, t_done, t_reply_c, t_retry;
  int               abort_c;
  logic [1:0]       t_type, t_status;
  logic [MSG_W-1:0] t_msg, t_reply;
  exp_t             pre;
  int               strobes[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] classify(input logic [1:0] typ, input logic [MSG_W-1:0] r);
    if (r[31:24] != PV) return 2'b11;
    else if (r[23:16] == 8'h7F) return 2'b01;
    else if (r[23:16] == 8'h01 + {6'd0, typ}) return 2'b00;
    else return 2'b11;
  endfunction

  function automatic logic [7:0] code_of(input logic [1:0] typ);
    case (typ)
      2'b00:   return 8'h81;
      2'b01:   return 8'h82;
      default: return 8'h83;
    endcase
  endfunction

  // Expected outputs in cycle c, from the transaction timeline.
  function automatic exp_t model(input int c);
    exp_t e;
    int   att, ofs;
    e = '0;
    if (!have_txn || c > abort_c) return e;
    if (c <= t_s) return pre;
    e    = pre;
    att  = (c - t_s - 1) / (T + 1);
    ofs  = (c - t_s - 1) % (T + 1);
    e.rr = (t_type != 2'b11) && (ofs == 0) && (att <= t_retry) && (c <= t_done);
    e.bz = (c <= t_done);
    e.dn = (c == t_done);
    e.st = (c < t_done) ? 2'b00 : t_status;
    e.rt = (t_type == 2'b11) ? '0 : RW'((att < t_retry) ? att : t_retry);
    if (t_type != 2'b11) e.msg = t_msg;
    if (t_reply_c >= 0 && c > t_reply_c) e.resp = t_reply;
    return e;
  endfunction

  // One cycle: compare outputs of the current cycle, then advance.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (chk_en) begin
      e = model(cyc);
      chk("read_req_out", {63'd0, read_req_out}, {63'd0, e.rr});
      chk("done_out", {63'd0, done_out}, {63'd0, e.dn});
      chk("busy_out", {63'd0, busy_out}, {63'd0, e.bz});
      chk("status_out", {62'd0, status_out}, {62'd0, e.st});
      chk("retry_cnt_out", {62'd0, retry_cnt_out}, {62'd0, e.rt});
      chk("auth_msg_init_out", {32'd0, auth_msg_init_out}, {32'd0, e.msg});
      chk("resp_msg_out", {32'd0, resp_msg_out}, {32'd0, e.resp});
    end
    if (read_req_out === 1'b1) strobes.push_back(cyc);
    @(posedge clk);
    cyc++;
    #1;
    start_in         = 1'b0;
    read_req_in      = 1'b0;
    req_type_in      = 2'($urandom);
    req_payload_in   = 16'($urandom);
    auth_msg_init_in = $urandom;
  endtask

  // Run one transaction. rd_off/xs_off/rst_off < 0 disable reply, extra
  // start and mid-transaction reset respectively.
  task automatic run_txn(input logic [1:0] typ, input logic [15:0] pl,
                         input int rd_off, input logic [MSG_W-1:0] reply,
                         input int xs_off, input int rst_off,
                         input int exp_done_off, input logic [1:0] exp_st,
                         input logic [1:0] exp_rt, input int nstr,
                         input int s0, input int s1, input int s2);
    int s;
    int so[3];
    so[0] = s0; so[1] = s1; so[2] = s2;
    s   = cyc;
    pre = model(cyc);
    have_txn = 1'b1;
    abort_c  = 1000000;
    t_s      = s;
    t_type   = typ;
    t_msg    = {PV, code_of(typ), pl};
    t_reply  = reply;
    if (typ == 2'b11) begin
      t_done = s + 1; t_status = 2'b11; t_retry = 0; t_reply_c = -1;
    end else if (rd_off >= 0) begin
      t_done = s + rd_off + 2; t_retry = (rd_off - 2) / (T + 1);
      t_status = classify(typ, reply); t_reply_c = s + rd_off;
    end else begin
      t_done = s + (M + 1) * (T + 1) + 1; t_retry = M;
      t_status = 2'b10; t_reply_c = -1;
    end
    if (exp_done_off >= 0) chk("model_done_offset", 64'(t_done - s), 64'(exp_done_off));
    strobes.delete();
    start_in       = 1'b1;
    req_type_in    = typ;
    req_payload_in = pl;
    for (int k = 0; k <= t_done - s + 2; k++) begin
      if (k == rd_off) begin
        read_req_in      = 1'b1;
        auth_msg_init_in = reply;
      end
      if (k == xs_off) begin
        start_in       = 1'b1;
        req_type_in    = 2'b00;
        req_payload_in = ~pl;
      end
      reset = (k == rst_off);
      if (k == rst_off) abort_c = cyc;
      step();
    end
    chk("strobe_count", 64'(strobes.size()), 64'(nstr));
    for (int i = 0; i < nstr && i < strobes.size(); i++)
      chk("strobe_offset", 64'(strobes[i] - s), 64'(so[i]));
    chk("final_status", {62'd0, status_out}, {62'd0, exp_st});
    chk("final_retry", {62'd0, retry_cnt_out}, {62'd0, exp_rt});
  endtask

  initial begin
    reset = 1'b1; start_in = 1'b0; read_req_in = 1'b0;
    req_type_in = 2'b00; req_payload_in = '0; auth_msg_init_in = '0;
    step(); step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    step();

    // GET_DIGESTS answered at cycle 4.
    run_txn(2'b00, 16'hA5A5, 4, 32'h0101_1234, -1, -1, 6, 2'b00, 2'd0, 1, 1, 0, 0);
    chk("req_type_byte", {56'd0, auth_msg_init_out[23:16]}, 64'h81);
    chk("resp_msg_pin", {32'd0, resp_msg_out}, 64'h0101_1234);
    // Stray response strobe in IDLE must not be captured.
    read_req_in = 1'b1; auth_msg_init_in = 32'hDEAD_BEEF;
    step(); step();
    chk("resp_after_idle_strobe", {32'd0, resp_msg_out}, 64'h0101_1234);

    // Silent responder: three attempts then timeout.
    run_txn(2'b01, 16'h0F0F, -1, '0, -1, -1, 28, 2'b10, 2'd2, 3, 1, 10, 19);
    // Reply during second attempt.
    run_txn(2'b01, 16'h1111, 12, 32'h0102_5555, -1, -1, 14, 2'b00, 2'd1, 2, 1, 10, 0);
    // Reply in the timeout cycle wins.
    run_txn(2'b00, 16'h2222, 9, 32'h0101_6666, -1, -1, 11, 2'b00, 2'd0, 1, 1, 0, 0);
    // CHALLENGE answered with ERROR, wrong type, wrong version.
    run_txn(2'b10, 16'h3333, 3, 32'h017F_0001, -1, -1, 5, 2'b01, 2'd0, 1, 1, 0, 0);
    run_txn(2'b10, 16'h4444, 3, 32'h0102_0002, -1, -1, 5, 2'b11, 2'd0, 1, 1, 0, 0);
    run_txn(2'b10, 16'h5555, 3, 32'h0203_0003, -1, -1, 5, 2'b11, 2'd0, 1, 1, 0, 0);
    // Reserved type: no strobe, immediate completion.
    run_txn(2'b11, 16'h6666, -1, '0, -1, -1, 1, 2'b11, 2'd0, 0, 0, 0, 0);
    // Second start during WAIT is ignored.
    run_txn(2'b10, 16'h7777, 6, 32'h0103_7777, 3, -1, 8, 2'b00, 2'd0, 1, 1, 0, 0);
    chk("msg_after_ignored_start", {32'd0, auth_msg_init_out}, 64'h0183_7777);
    // Reset during WAIT aborts with everything cleared.
    run_txn(2'b00, 16'h8888, -1, '0, -1, 4, -1, 2'b00, 2'd0, 1, 1, 0, 0);
    // Recovery after reset.
    run_txn(2'b01, 16'h9999, 3, 32'h0102_ABCD, -1, -1, 5, 2'b00, 2'd0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
